biu_gpio: RTL and testbench

- Parametrised successor of the 8-bit bidirectional bus interface unit.
- Provides a WIDTH-bit bidirectional pin port with per-bit direction control and synchronised input sampling.
- Supports set/clear output writes, per-bit rising/falling edge detection and a level interrupt.
- Sits between the SoC peripheral bus (single-cycle register access on clk) and the external pads.

---
 rtl/biu_gpio_if.sv | 22 ++
 rtl/biu_gpio.sv | 106 ++++++++++
 tb/tb_biu_gpio.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/biu_gpio_if.sv
// Register-bus bundle between the SoC peripheral bus and the GPIO block.
// Single-cycle strobes, no flow control; read data and interrupt come back from the slave.
interface biu_gpio_if #(
  parameter int WIDTH = 8
) ();
  logic [2:0]       addr;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             irq;

  modport master (
    output addr, wr_en, rd_en, wdata,
    input  rdata, irq
  );

  modport slave (
    input  addr, wr_en, rd_en, wdata,
    output rdata, irq
  );
endinterface

// File: rtl/biu_gpio.sv
// Bidirectional GPIO with synchronised inputs, set/clear writes and edge interrupts.
// Writes act on the strobe edge, reads return one cycle later; strobes are never stalled.
module biu_gpio #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] p,
  biu_gpio_if.slave        bus
);

  localparam int WARM = SYNC_STAGES + 1;
  localparam int CW   = $clog2(SYNC_STAGES + 2);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]    warm_q;

  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] rd_mux;
  logic             warm_done;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign p[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  assign in_sync   = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_q == CW'(WARM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      warm_q <= '0;
    end else begin
      sync_q[0] <= p;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= in_sync;
      // The zero-reset pipeline would otherwise look like edges on pins held high.
      if (!warm_done) warm_q <= warm_q + CW'(1);
    end
  end

  always_comb begin
    edge_hit = '0;
    if (warm_done)
      edge_hit = (in_sync & ~prev_q & rise_en_q) | (~in_sync & prev_q & fall_en_q);
  end

  always_comb begin
    w1c = '0;
    if (bus.wr_en && bus.addr == 3'd5) w1c = bus.wdata;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      3'd0:    rd_mux = out_q;
      3'd1:    rd_mux = dir_q;
      3'd2:    rd_mux = in_sync;
      3'd3:    rd_mux = rise_en_q;
      3'd4:    rd_mux = fall_en_q;
      3'd5:    rd_mux = status_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      rdata_q   <= '0;
    end else begin
      // New edges are OR-ed in after the clear so a colliding edge survives.
      status_q <= (status_q & ~w1c) | edge_hit;
      if (bus.wr_en) begin
        case (bus.addr)
          3'd0:    out_q     <= bus.wdata;
          3'd1:    dir_q     <= bus.wdata;
          3'd3:    rise_en_q <= bus.wdata;
          3'd4:    fall_en_q <= bus.wdata;
          3'd6:    out_q     <= out_q | bus.wdata;
          3'd7:    out_q     <= out_q & ~bus.wdata;
          default: ;
        endcase
      end
      if (bus.rd_en) rdata_q <= rd_mux;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.irq   = |(status_q & (rise_en_q | fall_en_q));

endmodule

// File: tb/tb_biu_gpio.sv
// Directed and randomised check of biu_gpio against a settled-pin reference model.
module tb_biu_gpio;
  localparam int W = 8;
  localparam int S = 2;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic [W-1:0] tb_val = '1;
  logic [W-1:0] tb_en  = '1;
  wire  [W-1:0] p;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_out    = '0;
  logic [W-1:0] m_dir    = '0;
  logic [W-1:0] m_rise   = '0;
  logic [W-1:0] m_fall   = '0;
  logic [W-1:0] m_status = '0;
  logic [W-1:0] m_last   = '1;

  biu_gpio_if #(.WIDTH(W)) bus ();

  biu_gpio #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .p     (p),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  for (genvar i = 0; i < W; i++) begin : g_drv
    assign p[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  // Resolved pin levels once everything has settled.
  function automatic logic [W-1:0] pins();
    return (m_out & m_dir) | (tb_val & ~m_dir);
  endfunction

  function automatic logic [W-1:0] reg_exp(input logic [2:0] a);
    case (a)
      3'd0:    return m_out;
      3'd1:    return m_dir;
      3'd2:    return pins();
      3'd3:    return m_rise;
      3'd4:    return m_fall;
      3'd5:    return m_status;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_irq(input string tag);
    chk(tag, W'(bus.irq), W'(|(m_status & (m_rise | m_fall))));
  endtask

  task automatic settle();
    logic [W-1:0] np;
    repeat (S + 2) @(negedge clk);
    np = pins();
    m_status = m_status | (np & ~m_last & m_rise) | (~np & m_last & m_fall);
    m_last = np;
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    bus.wr_en = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    case (a)
      3'd0: m_out = d;
      3'd1: m_dir = d;
      3'd3: m_rise = d;
      3'd4: m_fall = d;
      3'd5: m_status = m_status & ~d;
      3'd6: m_out = m_out | d;
      3'd7: m_out = m_out & ~d;
      default: ;
    endcase
  endtask

  task automatic rd(input logic [2:0] a, input string tag);
    logic [W-1:0] e;
    e = reg_exp(a);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk(tag, bus.rdata, e);
  endtask

  task automatic set_pins(input logic [W-1:0] v);
    tb_val = v;
    settle();
  endtask

  // Hand pins over without a glitch: both sides agree on the level during the swap.
  task automatic set_dir(input logic [W-1:0] nd);
    tb_val = (tb_val & ~(nd | m_dir)) | (m_out & (nd | m_dir));
    settle();
    tb_en = ~(m_dir & nd);
    wr(3'd1, nd);
    tb_en = ~nd;
  endtask

  initial begin
    bus.addr  = '0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wdata = '0;

    // Reset with pins held high; enabling rises right at release must not flag warm-up edges.
    repeat (3) @(negedge clk);
    chk("rst_irq", W'(bus.irq), '0);
    chk("rst_rdata", bus.rdata, '0);
    chk("rst_p_released", p, 8'hFF);
    rst_n = 1'b1;
    wr(3'd3, 8'hFF);
    repeat (6) @(negedge clk);
    rd(3'd5, "warm_status");
    rd(3'd0, "rst_out");
    rd(3'd1, "rst_dir");
    rd(3'd2, "rst_in");
    rd(3'd3, "rise_en_rb");
    rd(3'd4, "rst_fall_en");
    rd(3'd6, "rst_set_rd0");
    rd(3'd7, "rst_clr_rd0");
    wr(3'd3, 8'h00);

    // Output drive and loopback
    wr(3'd0, 8'hA5);
    set_dir(8'hFF);
    chk("p_drive", p, 8'hA5);
    settle();
    rd(3'd2, "in_loop");
    wr(3'd6, 8'h0A);
    rd(3'd0, "out_set");
    wr(3'd7, 8'h21);
    rd(3'd0, "out_clr");
    chk("p_clr", p, 8'h8E);
    settle();
    rd(3'd6, "set_rd0");
    rd(3'd7, "clr_rd0");

    // Read and write of OUT in the same cycle returns the old value
    bus.rd_en = 1'b1;
    bus.wr_en = 1'b1;
    bus.addr  = 3'd0;
    bus.wdata = 8'h33;
    @(negedge clk);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    m_out = 8'h33;
    chk("rdwr_old", bus.rdata, 8'h8E);
    settle();
    chk("rdata_hold", bus.rdata, 8'h8E);

    // Mixed direction
    wr(3'd0, 8'hFF);
    settle();
    set_dir(8'h0F);
    set_pins(8'h50);
    rd(3'd2, "mixed_in");
    chk("mixed_p", p, 8'h5F);

    // Edge interrupts
    set_dir(8'h00);
    set_pins(8'h80);
    wr(3'd3, 8'h01);
    wr(3'd4, 8'h80);
    wr(3'd5, 8'hFF);
    set_pins(8'h81);
    rd(3'd5, "rise_status");
    chk_irq("rise_irq");
    set_pins(8'h01);
    rd(3'd5, "fall_status");
    wr(3'd5, 8'h01);
    rd(3'd5, "w1c_status");
    chk_irq("w1c_irq_hold");
    wr(3'd5, 8'h80);
    chk_irq("w1c_irq_drop");

    // Randomised enables, pin patterns, clears and set/clear writes
    for (int it = 0; it < 10; it++) begin
      wr(3'd3, W'($urandom()));
      wr(3'd4, W'($urandom()));
      set_pins(W'($urandom()));
      rd(3'd5, "rnd_status");
      chk_irq("rnd_irq");
      wr(3'd5, W'($urandom()));
      rd(3'd5, "rnd_w1c");
      chk_irq("rnd_w1c_irq");
      wr(($urandom() & 1) != 0 ? 3'd6 : 3'd7, W'($urandom()));
      wr(3'd2, W'($urandom()));
      rd(3'd0, "rnd_out");
      rd(3'd2, "rnd_in");
    end

    // Rising edge lands on the same edge as its W1C
    wr(3'd3, 8'h01);
    wr(3'd4, 8'h00);
    set_pins(8'h00);
    wr(3'd5, 8'hFF);
    tb_val = 8'h01;
    repeat (S) @(negedge clk);
    bus.wr_en = 1'b1;
    bus.addr  = 3'd5;
    bus.wdata = 8'h01;
    @(negedge clk);
    bus.wr_en = 1'b0;
    m_status = (m_status & ~8'h01) | 8'h01;
    m_last   = 8'h01;
    chk_irq("coll_irq");
    rd(3'd5, "coll_status");
    wr(3'd3, 8'h00);
    rd(3'd5, "en_clr_keeps");
    chk_irq("en_clr_irq");

    // Reset in the middle of operation
    wr(3'd3, 8'h01);
    wr(3'd0, 8'h3C);
    set_dir(8'hFF);
    chk_irq("pre_rst_irq");
    #2;
    rst_n  = 1'b0;
    tb_en  = '1;
    tb_val = 8'hC3;
    #1;
    chk("mid_rst_p", p, 8'hC3);
    chk("mid_rst_irq", W'(bus.irq), '0);
    chk("mid_rst_rdata", bus.rdata, '0);
    @(negedge clk);
    rst_n    = 1'b1;
    m_out    = '0;
    m_dir    = '0;
    m_rise   = '0;
    m_fall   = '0;
    m_status = '0;
    m_last   = 8'hC3;
    repeat (S + 3) @(negedge clk);
    rd(3'd0, "post_out");
    rd(3'd1, "post_dir");
    rd(3'd2, "post_in");
    rd(3'd3, "post_rise");
    rd(3'd4, "post_fall");
    rd(3'd5, "post_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
